// File: rtl/iob_cache_be_mem_if.sv
// Native memory-port bundle between the cache back-end (master) and the
// backing memory (slave).
interface iob_cache_be_mem_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
);
    logic                  mem_valid;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W/8-1:0]   mem_wstrb;
    logic [DATA_W-1:0]     mem_rdata;
    logic                  mem_ready;

    modport master (
        output mem_valid, mem_addr, mem_wdata, mem_wstrb,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/iob_cache_be_mem.sv
// Byte-writable backing memory for the cache's native port, answering each
// request with a one-cycle ready pulse after RD_LAT/WR_LAT cycles.
module iob_cache_be_mem #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 64,
    parameter int MEM_ADDR_W = 14,
    parameter int RD_LAT     = 1,
    parameter int WR_LAT     = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    iob_cache_be_mem_if.slave       mem,
    output logic                    busy
);
    localparam int STRB_W  = DATA_W / 8;
    localparam int OFF_W   = $clog2(STRB_W);
    localparam int WORD_AW = MEM_ADDR_W - OFF_W;
    localparam int DEPTH   = 1 << WORD_AW;

    localparam logic [3:0] RD_LAT_C = 4'(RD_LAT);
    localparam logic [3:0] WR_LAT_C = 4'(WR_LAT);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [3:0]          lat_q, lat_d;
    logic                is_rd_q, is_rd_d;
    logic                ready_q, ready_d;
    logic                busy_q, busy_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [DATA_W-1:0]   hold_q, hold_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                accept;
    logic                req_rd;
    logic [3:0]          req_lat;
    logic [WORD_AW-1:0]  word_idx;
    logic                unused_addr;

    // Upper bits alias and byte-offset bits are don't-care.
    assign word_idx    = mem.mem_addr[MEM_ADDR_W-1:OFF_W];
    assign unused_addr = ^mem.mem_addr;
    assign req_rd      = (mem.mem_wstrb == '0);
    assign req_lat     = req_rd ? RD_LAT_C : WR_LAT_C;
    assign accept      = reset && (state_q == IDLE) && mem.mem_valid;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lat_d   = lat_q;
        is_rd_d = is_rd_q;
        hold_d  = hold_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (mem.mem_valid) begin
                    cnt_d   = '0;
                    lat_d   = req_lat;
                    is_rd_d = req_rd;
                    if (req_rd) begin
                        hold_d = mem_q[word_idx];
                    end
                    state_d = (req_lat == 4'd1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_d == lat_q - 4'd1) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // With a single-cycle latency the fetched word bypasses the hold flop.
        if ((state_d == RESP) && (state_q != RESP) && is_rd_d) begin
            rdata_d = hold_d;
        end
    end

    assign ready_d = (state_d == RESP);
    assign busy_d  = (state_d != IDLE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            lat_q   <= '0;
            is_rd_q <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            rdata_q <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lat_q   <= lat_d;
            is_rd_q <= is_rd_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            rdata_q <= rdata_d;
            hold_q  <= hold_d;
        end
    end

    // Array is deliberately left out of reset so contents survive it.
    always_ff @(posedge clk) begin
        if (accept && !req_rd) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (mem.mem_wstrb[i]) begin
                    mem_q[word_idx][8*i +: 8] <= mem.mem_wdata[8*i +: 8];
                end
            end
        end
    end

    assign mem.mem_ready = ready_q;
    assign mem.mem_rdata = rdata_q;
    assign busy          = busy_q;
endmodule
